// File: rtl/perceptron_datapath.sv
// perceptron_datapath: sample memory, sample/epoch counters, weights, bias and error register
// for a single-layer perceptron trainer driven by an external control FSM.
module perceptron_datapath #(
    parameter int N_FEAT    = 2,
    parameter int N_SAMPLES = 4,
    parameter int N_EPOCHS  = 10,
    parameter int W         = 8,
    parameter int LR_SHIFT  = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ld_N,
    input  logic                              clr_N,
    input  logic                              ld_Ep,
    input  logic                              clr_Ep,
    input  logic                              ld_w,
    input  logic                              clr_w,
    input  logic                              ld_e,
    input  logic                              clr_e,
    input  logic                              mem_we,
    input  logic [$clog2(N_SAMPLES)-1:0]      mem_addr,
    input  logic [N_FEAT*W-1:0]               mem_x,
    input  logic                              mem_t,
    output logic                              Epm,
    output logic                              Nm,
    output logic                              y_pred,
    output logic signed [1:0]                 e_q,
    output logic [N_FEAT*W-1:0]               w_flat,
    output logic signed [W-1:0]               bias,
    output logic [$clog2(N_SAMPLES)-1:0]      n_idx,
    output logic [$clog2(N_EPOCHS+1)-1:0]     ep_cnt,
    output logic                              train_done
);
    localparam int AW = $clog2(N_SAMPLES);
    localparam int EW = $clog2(N_EPOCHS+1);
    localparam int SW = 2*W + $clog2(N_FEAT+1);
    localparam int XW = N_FEAT*W;
    localparam logic signed [W+1:0] MAXV = (W+2)'(2**(W-1)-1);
    localparam logic signed [W+1:0] MINV = (W+2)'(-(2**(W-1)));

    logic [XW:0]              mem_q [N_SAMPLES];
    logic [XW-1:0]            x_cur;
    logic                     t_cur;
    logic signed [W-1:0]      x_s [N_FEAT];
    logic signed [W-1:0]      w_s [N_FEAT];
    logic signed [2*W-1:0]    prod [N_FEAT];
    logic signed [W+1:0]      delta [N_FEAT];
    logic signed [W+1:0]      upd [N_FEAT];
    logic signed [W+1:0]      bias_upd;
    logic signed [SW-1:0]     sum;
    logic signed [1:0]        err, e_d;
    logic [AW-1:0]            n_idx_d, n_idx_q;
    logic [EW-1:0]            ep_cnt_d, ep_cnt_q;
    logic                     train_done_d, train_done_q;
    logic [XW-1:0]            w_d, w_q;
    logic signed [W-1:0]      bias_d, bias_q;

    function automatic logic [W-1:0] sat(input logic signed [W+1:0] v);
        return v > MAXV ? MAXV[W-1:0] : v < MINV ? MINV[W-1:0] : v[W-1:0];
    endfunction

    always_ff @(posedge clk) if (mem_we) mem_q[mem_addr] <= {mem_t, mem_x};

    assign {t_cur, x_cur} = mem_q[n_idx_q];

    // sum is wide enough for every product plus bias, so the sign bit is the prediction
    always_comb begin
        sum = SW'(bias_q);
        for (int i = 0; i < N_FEAT; i++) begin
            x_s[i]   = x_cur[i*W +: W];
            w_s[i]   = w_q[i*W +: W];
            prod[i]  = (2*W)'(x_s[i]) * (2*W)'(w_s[i]);
            delta[i] = ((W+2)'(e_q) * (W+2)'(x_s[i])) >>> LR_SHIFT;
            upd[i]   = (W+2)'(w_s[i]) + delta[i];
            sum      = sum + SW'(prod[i]);
        end
    end

    assign bias_upd = (W+2)'(bias_q) + ((W+2)'(e_q) >>> LR_SHIFT);
    assign y_pred   = ~sum[SW-1];
    assign err      = {1'b0, t_cur} - {1'b0, y_pred};
    assign Nm       = n_idx_q != AW'(N_SAMPLES-1);
    assign Epm      = ep_cnt_q < EW'(N_EPOCHS);

    always_comb begin
        n_idx_d      = clr_N ? '0 : !ld_N ? n_idx_q : Nm ? n_idx_q + AW'(1) : '0;
        ep_cnt_d     = clr_Ep ? '0 : (ld_Ep && Epm) ? ep_cnt_q + EW'(1) : ep_cnt_q;
        train_done_d = !clr_Ep && (train_done_q || (ld_Ep && ep_cnt_q == EW'(N_EPOCHS)));
        e_d          = clr_e ? 2'sd0 : ld_e ? err : e_q;
        bias_d       = clr_w ? '0 : ld_w ? sat(bias_upd) : bias_q;
        w_d          = w_q;
        for (int i = 0; i < N_FEAT; i++)
            w_d[i*W +: W] = clr_w ? '0 : ld_w ? sat(upd[i]) : w_q[i*W +: W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_idx_q      <= '0;
            ep_cnt_q     <= '0;
            train_done_q <= 1'b0;
            e_q          <= '0;
            w_q          <= '0;
            bias_q       <= '0;
        end else begin
            n_idx_q      <= n_idx_d;
            ep_cnt_q     <= ep_cnt_d;
            train_done_q <= train_done_d;
            e_q          <= e_d;
            w_q          <= w_d;
            bias_q       <= bias_d;
        end
    end

    assign w_flat     = w_q;
    assign bias       = bias_q;
    assign n_idx      = n_idx_q;
    assign ep_cnt     = ep_cnt_q;
    assign train_done = train_done_q;
endmodule

// File: tb/tb_perceptron_datapath.sv
// tb_perceptron_datapath: directed stimulus for the perceptron datapath, checked every cycle
// against an arithmetic model of the training rules plus hand-computed literals.
module tb_perceptron_datapath;
    localparam int NS = 4, NE = 10, LRS = 0;
    localparam logic [7:0] S_LDN = 8'h80, S_CLRN = 8'h40, S_LDEP = 8'h20, S_CLREP = 8'h10;
    localparam logic [7:0] S_LDW = 8'h08, S_CLRW = 8'h04, S_LDE = 8'h02, S_CLRE = 8'h01;

    logic clk = 1'b0, rst;
    logic [7:0] st;
    logic ld_N, clr_N, ld_Ep, clr_Ep, ld_w, clr_w, ld_e, clr_e;
    logic mem_we, mem_t;
    logic [1:0] mem_addr;
    logic [15:0] mem_x;
    logic Epm, Nm, y_pred, train_done;
    logic signed [1:0] e_q;
    logic [15:0] w_flat;
    logic signed [7:0] bias;
    logic [1:0] n_idx;
    logic [3:0] ep_cnt;

    int vectors = 0, miscompares = 0;
    int m_n = 0, m_ep = 0, m_done = 0, m_e = 0, m_b = 0;
    int m_w [2] = '{0, 0};
    int m_x [NS][2];
    int m_t [NS];
    bit m_valid [NS] = '{default: 1'b0};

    assign {ld_N, clr_N, ld_Ep, clr_Ep, ld_w, clr_w, ld_e, clr_e} = st;

    perceptron_datapath dut (
        .clk(clk), .rst(rst), .ld_N(ld_N), .clr_N(clr_N), .ld_Ep(ld_Ep), .clr_Ep(clr_Ep),
        .ld_w(ld_w), .clr_w(clr_w), .ld_e(ld_e), .clr_e(clr_e), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_x(mem_x), .mem_t(mem_t), .Epm(Epm), .Nm(Nm),
        .y_pred(y_pred), .e_q(e_q), .w_flat(w_flat), .bias(bias), .n_idx(n_idx),
        .ep_cnt(ep_cnt), .train_done(train_done)
    );

    always #5 clk = ~clk;

    function automatic int msum();
        int s = m_b;
        for (int i = 0; i < 2; i++) s += m_w[i] * m_x[m_n][i];
        return s;
    endfunction

    function automatic int clamp(int v);
        return v > 127 ? 127 : v < -128 ? -128 : v;
    endfunction

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_n <= 0; m_ep <= 0; m_done <= 0; m_e <= 0; m_b <= 0;
            m_w[0] <= 0; m_w[1] <= 0;
        end else begin
            if (mem_we) begin
                m_x[mem_addr][0] <= int'($signed(mem_x[7:0]));
                m_x[mem_addr][1] <= int'($signed(mem_x[15:8]));
                m_t[mem_addr]    <= int'(mem_t);
                m_valid[mem_addr] <= 1'b1;
            end
            m_n    <= clr_N ? 0 : ld_N ? (m_n + 1) % NS : m_n;
            m_ep   <= clr_Ep ? 0 : (ld_Ep && m_ep < NE) ? m_ep + 1 : m_ep;
            m_done <= clr_Ep ? 0 : (ld_Ep && m_ep == NE) ? 1 : m_done;
            m_e    <= clr_e ? 0 : ld_e ? m_t[m_n] - int'(msum() >= 0) : m_e;
            m_b    <= clr_w ? 0 : ld_w ? clamp(m_b + (m_e >>> LRS)) : m_b;
            for (int i = 0; i < 2; i++)
                m_w[i] <= clr_w ? 0 : ld_w ? clamp(m_w[i] + ((m_e * m_x[m_n][i]) >>> LRS)) : m_w[i];
        end
    end

    always @(negedge clk) begin
        chk("n_idx", int'(n_idx), m_n);
        chk("ep_cnt", int'(ep_cnt), m_ep);
        chk("train_done", int'(train_done), m_done);
        chk("Nm", int'(Nm), int'(m_n != NS - 1));
        chk("Epm", int'(Epm), int'(m_ep < NE));
        chk("e_q", int'(e_q), m_e);
        chk("w0", int'($signed(w_flat[7:0])), m_w[0]);
        chk("w1", int'($signed(w_flat[15:8])), m_w[1]);
        chk("bias", int'(bias), m_b);
        if (m_valid[m_n]) chk("y_pred", int'(y_pred), int'(msum() >= 0));
    end

    task automatic strobe(input logic [7:0] s);
        st = s;
        @(negedge clk);
        st = '0;
    endtask

    task automatic wr(input int a, input int x0, input int x1, input int t);
        mem_we = 1'b1; mem_addr = a[1:0]; mem_x = {8'(x1), 8'(x0)}; mem_t = t[0];
        @(negedge clk);
        mem_we = 1'b0;
    endtask

    task automatic chk_cleared(string tag);
        chk({tag, "_n"}, int'(n_idx), 0);
        chk({tag, "_ep"}, int'(ep_cnt), 0);
        chk({tag, "_e"}, int'(e_q), 0);
        chk({tag, "_w"}, int'(w_flat), 0);
        chk({tag, "_bias"}, int'(bias), 0);
        chk({tag, "_done"}, int'(train_done), 0);
        chk({tag, "_Nm"}, int'(Nm), 1);
        chk({tag, "_Epm"}, int'(Epm), 1);
    endtask

    initial begin
        st = '0; mem_we = 1'b0; mem_addr = '0; mem_x = '0; mem_t = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        chk_cleared("rst");
        rst = 1'b1;

        strobe(S_CLRN);
        repeat (3) strobe(S_LDN);
        chk("ncnt3", int'(n_idx), 3);
        chk("ncnt3_Nm", int'(Nm), 0);
        strobe(S_LDN);
        chk("nwrap", int'(n_idx), 0);
        chk("nwrap_Nm", int'(Nm), 1);

        strobe(S_CLREP);
        repeat (10) strobe(S_LDEP);
        chk("ep10", int'(ep_cnt), 10);
        chk("ep10_Epm", int'(Epm), 0);
        chk("ep10_done", int'(train_done), 0);
        strobe(S_LDEP);
        chk("ep11", int'(ep_cnt), 10);
        chk("ep11_done", int'(train_done), 1);

        wr(0, -100, -100, 0);
        strobe(S_CLRN | S_CLRW | S_CLRE);
        strobe(S_LDE);
        chk("sat_e", int'(e_q), -1);
        strobe(S_LDW);
        chk("sat1_w0", int'($signed(w_flat[7:0])), 100);
        chk("sat1_w1", int'($signed(w_flat[15:8])), 100);
        chk("sat1_bias", int'(bias), -1);
        strobe(S_LDW);
        chk("sat2_w0", int'($signed(w_flat[7:0])), 127);
        chk("sat2_w1", int'($signed(w_flat[15:8])), 127);
        chk("sat2_bias", int'(bias), -2);

        strobe(S_CLRW | S_LDW);
        chk("prio_w", int'(w_flat), 0);
        chk("prio_bias", int'(bias), 0);
        strobe(S_CLRE | S_LDE);
        chk("prio_e", int'(e_q), 0);

        strobe(S_LDE);
        st = S_LDN | S_LDW | S_LDEP | S_LDE;
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_cleared("midrst");
        @(negedge clk);
        st = '0;
        rst = 1'b1;

        wr(0, 0, 0, 0);
        wr(1, 0, 1, 0);
        wr(2, 1, 0, 0);
        wr(3, 1, 1, 1);
        strobe(S_CLRN | S_CLREP | S_CLRW | S_CLRE);
        for (int ep = 0; ep < NE; ep++) begin
            for (int s = 0; s < NS; s++) begin
                strobe(S_LDE);
                if (ep == 0 && s == 0) chk("and_first_e", int'(e_q), -1);
                strobe(S_LDW | S_LDN);
                if (ep == 0 && s == 0) begin
                    chk("and_first_bias", int'(bias), -1);
                    chk("and_first_w", int'(w_flat), 0);
                end
            end
            strobe(S_LDEP);
        end
        chk("and_Epm", int'(Epm), 0);
        chk("and_done_pre", int'(train_done), 0);
        strobe(S_LDEP);
        chk("and_done", int'(train_done), 1);
        chk("and_w0", int'($signed(w_flat[7:0])), 2);
        chk("and_w1", int'($signed(w_flat[15:8])), 1);
        chk("and_bias", int'(bias), -3);
        for (int s = 0; s < NS; s++) begin
            chk($sformatf("and_y%0d", s), int'(y_pred), int'(s == 3));
            strobe(S_LDN);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
